// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and sizing helpers for the SDRAM Avalon arbiter
package sdram_arb_pkg;

  localparam int ADDR_W_DEF = 25;
  localparam int DATA_W_DEF = 16;

  typedef enum logic {
    G0 = 1'b0,
    G1 = 1'b1
  } grant_t;

  // Width of an occupancy counter that must hold 0..depth inclusive
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sdram_avalon_arbiter_if.sv
// rtl/sdram_avalon_arbiter_if.sv - Avalon-MM port bundle shared by masters and the SDRAM slave
interface sdram_avalon_arbiter_if
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/arb_id_fifo.sv
// rtl/arb_id_fifo.sv - 1-bit ID FIFO remembering which master owns each outstanding read
module arb_id_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     din,
  output logic                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [cnt_w(DEPTH)-1:0]  count
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sdram_avalon_arbiter.sv
// rtl/sdram_avalon_arbiter.sv - two-master round-robin arbiter in front of the SDRAM controller
module sdram_avalon_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MAX_PENDING = 8
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  sdram_avalon_arbiter_if.slave         m0,
  sdram_avalon_arbiter_if.slave         m1,
  sdram_avalon_arbiter_if.master        s,
  output logic [cnt_w(MAX_PENDING)-1:0] pending_cnt,
  output logic                          err_orphan
);

  localparam int CW = cnt_w(MAX_PENDING);

  grant_t              grant;
  grant_t              grant_nxt;
  logic                req0;
  logic                req1;
  logic                gnt_rd;
  logic                gnt_wr;
  logic [ADDR_W-1:0]   gnt_addr;
  logic [DATA_W-1:0]   gnt_wdata;
  logic [DATA_W/8-1:0] gnt_be;
  logic                read_blocked;
  logic                cmd_rd;
  logic                cmd_wr;
  logic                accept;
  logic                rdv_ok;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_head;
  logic [CW-1:0]       fifo_count;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  // Command mux: the granted master's fields go straight to the controller
  always_comb begin
    if (grant == G1) begin
      gnt_rd    = m1.read;
      gnt_wr    = m1.write;
      gnt_addr  = m1.address;
      gnt_wdata = m1.writedata;
      gnt_be    = m1.byteenable;
    end else begin
      gnt_rd    = m0.read;
      gnt_wr    = m0.write;
      gnt_addr  = m0.address;
      gnt_wdata = m0.writedata;
      gnt_be    = m0.byteenable;
    end
  end

  // Reads stall only while every ID slot is taken; writes never need one
  assign read_blocked = gnt_rd & fifo_full;
  assign cmd_rd       = reset_reset_n & gnt_rd & ~fifo_full;
  assign cmd_wr       = reset_reset_n & gnt_wr;
  assign accept       = (cmd_rd | cmd_wr) & ~s.waitrequest;
  assign rdv_ok       = reset_reset_n & s.readdatavalid & ~fifo_empty;

  // Next grant: hand over only on an accepted command or when the holder is idle
  always_comb begin
    grant_nxt = grant;
    if (grant == G0) begin
      if (req1 && (accept || !req0)) grant_nxt = G1;
    end else begin
      if (req0 && (accept || !req1)) grant_nxt = G0;
    end
  end

  // Grant register, parked on the last winner
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) grant <= G0;
    else                grant <= grant_nxt;
  end

  // Slave command, per-master stalls and read-return routing
  always_comb begin
    s.address        = gnt_addr;
    s.writedata      = gnt_wdata;
    s.byteenable     = gnt_be;
    s.read           = cmd_rd;
    s.write          = cmd_wr;
    m0.waitrequest   = 1'b1;
    m1.waitrequest   = 1'b1;
    if (reset_reset_n) begin
      if (grant == G0) m0.waitrequest = s.waitrequest | read_blocked;
      else             m1.waitrequest = s.waitrequest | read_blocked;
    end
    m0.readdata      = s.readdata;
    m1.readdata      = s.readdata;
    m0.readdatavalid = rdv_ok & ~fifo_head;
    m1.readdatavalid = rdv_ok & fifo_head;
  end

  arb_id_fifo #(
    .DEPTH (MAX_PENDING)
  ) u_id_fifo (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .push  (accept & cmd_rd),
    .pop   (s.readdatavalid),
    .din   (grant == G1),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign pending_cnt = fifo_count;

  // Sticky orphan flag: return data with no matching outstanding read
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)                          err_orphan <= 1'b0;
    else if (s.readdatavalid && fifo_empty)      err_orphan <= 1'b1;
  end

endmodule

// File: tb/tb_sdram_avalon_arbiter.sv
// tb/tb_sdram_avalon_arbiter.sv - directed vector bench for the SDRAM Avalon arbiter
module tb_sdram_avalon_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] pending_cnt;
  logic       err_orphan;
  int         checks = 0;
  int         errors = 0;

  logic       f_push = 1'b0;
  logic       f_pop = 1'b0;
  logic       f_din = 1'b0;
  logic       f_dout;
  logic       f_full;
  logic       f_empty;
  logic [3:0] f_count;

  sdram_avalon_arbiter_if #(.ADDR_W(25), .DATA_W(16)) m0_bus ();
  sdram_avalon_arbiter_if #(.ADDR_W(25), .DATA_W(16)) m1_bus ();
  sdram_avalon_arbiter_if #(.ADDR_W(25), .DATA_W(16)) s_bus ();

  sdram_avalon_arbiter #(.ADDR_W(25), .DATA_W(16), .MAX_PENDING(8)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .m0            (m0_bus),
    .m1            (m1_bus),
    .s             (s_bus),
    .pending_cnt   (pending_cnt),
    .err_orphan    (err_orphan)
  );

  arb_id_fifo #(.DEPTH(8)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (f_push),
    .pop   (f_pop),
    .din   (f_din),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m0_rd, m0_wr, m1_rd, m1_wr;
    logic [24:0] m0_a, m1_a;
    logic [15:0] m0_wd, m1_wd;
    logic        s_wait, s_rdv;
    logic [15:0] s_rdata;
    logic        e_rd, e_wr, e_w0, e_w1, e_v0, e_v1, e_err;
    logic [24:0] e_a;
    logic [15:0] e_wd;
    logic [3:0]  e_cnt;
  } vec_t;

  typedef struct {
    int          due;
    logic [15:0] d;
  } ret_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t v(input logic [3:0] cmd, input logic [24:0] a0, input logic [15:0] wd0,
                             input logic [24:0] a1, input logic [15:0] wd1, input logic [1:0] sl,
                             input logic [15:0] rd, input logic [3:0] eo, input logic [24:0] ea,
                             input logic [15:0] ewd, input logic [1:0] ev, input logic [3:0] ecnt,
                             input logic eerr);
    vec_t t;
    {t.m0_rd, t.m0_wr, t.m1_rd, t.m1_wr} = cmd;
    t.m0_a = a0;  t.m0_wd = wd0;
    t.m1_a = a1;  t.m1_wd = wd1;
    {t.s_wait, t.s_rdv} = sl;
    t.s_rdata = rd;
    {t.e_rd, t.e_wr, t.e_w0, t.e_w1} = eo;
    t.e_a = ea;  t.e_wd = ewd;
    {t.e_v0, t.e_v1} = ev;
    t.e_cnt = ecnt;
    t.e_err = eerr;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_bus.read = 1'b0; m0_bus.write = 1'b0; m0_bus.address = '0;
    m0_bus.writedata = '0; m0_bus.byteenable = 2'b11;
    m1_bus.read = 1'b0; m1_bus.write = 1'b0; m1_bus.address = '0;
    m1_bus.writedata = '0; m1_bus.byteenable = 2'b11;
    s_bus.waitrequest = 1'b0; s_bus.readdatavalid = 1'b0; s_bus.readdata = '0;
  endtask

  task automatic apply(input vec_t t);
    m0_bus.read = t.m0_rd; m0_bus.write = t.m0_wr; m0_bus.address = t.m0_a;
    m0_bus.writedata = t.m0_wd; m0_bus.byteenable = 2'b11;
    m1_bus.read = t.m1_rd; m1_bus.write = t.m1_wr; m1_bus.address = t.m1_a;
    m1_bus.writedata = t.m1_wd; m1_bus.byteenable = 2'b11;
    s_bus.waitrequest = t.s_wait; s_bus.readdatavalid = t.s_rdv; s_bus.readdata = t.s_rdata;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One cycle of master-0-only traffic, sampled at the following negedge
  task automatic cyc0(input logic rd, input logic wr, input logic [24:0] a, input logic rdv);
    @(posedge clk); #1;
    idle_inputs();
    m0_bus.read = rd; m0_bus.write = wr; m0_bus.address = a; m0_bus.writedata = 16'h5555;
    s_bus.readdatavalid = rdv; s_bus.readdata = 16'h1234;
    @(negedge clk);
  endtask

  initial begin
    int          i0, i1, n0, n1, cyc, peak, n_acc;
    logic [24:0] exp_ord [6];
    logic [15:0] exp_dat;
    ret_t        rq [$];
    logic        fexp [8];

    // ---- reset state while masters are already requesting ----
    idle_inputs();
    m0_bus.read = 1'b1; m1_bus.read = 1'b1; s_bus.readdatavalid = 1'b1;
    #2;
    chk("rst s_read", s_bus.read, 0);
    chk("rst s_write", s_bus.write, 0);
    chk("rst m0_wait", m0_bus.waitrequest, 1);
    chk("rst m1_wait", m1_bus.waitrequest, 1);
    chk("rst m0_rdv", m0_bus.readdatavalid, 0);
    chk("rst m1_rdv", m1_bus.readdatavalid, 0);
    chk("rst pending", pending_cnt, 0);
    chk("rst err", err_orphan, 0);
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ---- table: writes, stalled read, routing, orphan, switch latency ----
    //                cmd      a0      wd0       a1      wd1     sl     rdata     eo       ea      ewd      ev     cnt  err
    vecs[0]  = v(4'b0100, 25'h10, 16'hA0, 25'h0,  16'h0, 2'b00, 16'h0,    4'b0101, 25'h10, 16'hA0, 2'b00, 4'd0, 1'b0);
    vecs[1]  = v(4'b0100, 25'h11, 16'hA1, 25'h0,  16'h0, 2'b00, 16'h0,    4'b0101, 25'h11, 16'hA1, 2'b00, 4'd0, 1'b0);
    vecs[2]  = v(4'b0100, 25'h12, 16'hA2, 25'h0,  16'h0, 2'b00, 16'h0,    4'b0101, 25'h12, 16'hA2, 2'b00, 4'd0, 1'b0);
    vecs[3]  = v(4'b0100, 25'h13, 16'hA3, 25'h0,  16'h0, 2'b00, 16'h0,    4'b0101, 25'h13, 16'hA3, 2'b00, 4'd0, 1'b0);
    vecs[4]  = v(4'b0000, 25'h0,  16'h0,  25'h0,  16'h0, 2'b00, 16'h0,    4'b0001, 25'h0,  16'h0,  2'b00, 4'd0, 1'b0);
    for (int k = 5; k <= 10; k++)
      vecs[k] = v(4'b1010, 25'h20, 16'h0, 25'h30, 16'h0, 2'b10, 16'h0,    4'b1011, 25'h20, 16'h0,  2'b00, 4'd0, 1'b0);
    vecs[11] = v(4'b1010, 25'h20, 16'h0,  25'h30, 16'h0, 2'b00, 16'h0,    4'b1001, 25'h20, 16'h0,  2'b00, 4'd0, 1'b0);
    vecs[12] = v(4'b0010, 25'h0,  16'h0,  25'h30, 16'h0, 2'b00, 16'h0,    4'b1010, 25'h30, 16'h0,  2'b00, 4'd1, 1'b0);
    vecs[13] = v(4'b0000, 25'h0,  16'h0,  25'h0,  16'h0, 2'b01, 16'hBEEF, 4'b0010, 25'h0,  16'h0,  2'b10, 4'd2, 1'b0);
    vecs[14] = v(4'b0000, 25'h0,  16'h0,  25'h0,  16'h0, 2'b01, 16'hCAFE, 4'b0010, 25'h0,  16'h0,  2'b01, 4'd1, 1'b0);
    vecs[15] = v(4'b0000, 25'h0,  16'h0,  25'h0,  16'h0, 2'b00, 16'h0,    4'b0010, 25'h0,  16'h0,  2'b00, 4'd0, 1'b0);
    vecs[16] = v(4'b0000, 25'h0,  16'h0,  25'h0,  16'h0, 2'b01, 16'hDEAD, 4'b0010, 25'h0,  16'h0,  2'b00, 4'd0, 1'b0);
    vecs[17] = v(4'b0000, 25'h0,  16'h0,  25'h0,  16'h0, 2'b00, 16'h0,    4'b0010, 25'h0,  16'h0,  2'b00, 4'd0, 1'b1);
    vecs[18] = v(4'b0100, 25'h40, 16'h44, 25'h0,  16'h0, 2'b00, 16'h0,    4'b0010, 25'h0,  16'h0,  2'b00, 4'd0, 1'b1);
    vecs[19] = v(4'b0100, 25'h40, 16'h44, 25'h0,  16'h0, 2'b00, 16'h0,    4'b0101, 25'h40, 16'h44, 2'b00, 4'd0, 1'b1);
    vecs[20] = v(4'b0000, 25'h0,  16'h0,  25'h0,  16'h0, 2'b00, 16'h0,    4'b0001, 25'h0,  16'h0,  2'b00, 4'd0, 1'b1);

    for (int k = 0; k < NV; k++) begin
      @(posedge clk); #1;
      apply(vecs[k]);
      @(negedge clk);
      chk($sformatf("v%0d s_read", k), s_bus.read, vecs[k].e_rd);
      chk($sformatf("v%0d s_write", k), s_bus.write, vecs[k].e_wr);
      chk($sformatf("v%0d s_address", k), s_bus.address, vecs[k].e_a);
      chk($sformatf("v%0d s_writedata", k), s_bus.writedata, vecs[k].e_wd);
      chk($sformatf("v%0d m0_wait", k), m0_bus.waitrequest, vecs[k].e_w0);
      chk($sformatf("v%0d m1_wait", k), m1_bus.waitrequest, vecs[k].e_w1);
      chk($sformatf("v%0d m0_rdv", k), m0_bus.readdatavalid, vecs[k].e_v0);
      chk($sformatf("v%0d m1_rdv", k), m1_bus.readdatavalid, vecs[k].e_v1);
      chk($sformatf("v%0d m0_rdata", k), m0_bus.readdata, vecs[k].s_rdata);
      chk($sformatf("v%0d m1_rdata", k), m1_bus.readdata, vecs[k].s_rdata);
      chk($sformatf("v%0d pending", k), pending_cnt, vecs[k].e_cnt);
      chk($sformatf("v%0d err", k), err_orphan, vecs[k].e_err);
    end

    // ---- both masters, 3 reads each, controller latency 5 ----
    do_reset();
    chk("t2 err cleared", err_orphan, 0);
    exp_ord[0] = 25'h100; exp_ord[1] = 25'h200; exp_ord[2] = 25'h101;
    exp_ord[3] = 25'h201; exp_ord[4] = 25'h102; exp_ord[5] = 25'h202;
    i0 = 0; i1 = 0; n0 = 0; n1 = 0; cyc = 0; peak = 0; n_acc = 0;
    while ((n0 < 3 || n1 < 3 || cyc < 14) && cyc < 60) begin
      @(posedge clk); #1;
      m0_bus.read = (i0 < 3); m0_bus.address = 25'h100 + 25'(i0);
      m1_bus.read = (i1 < 3); m1_bus.address = 25'h200 + 25'(i1);
      s_bus.readdatavalid = (rq.size() > 0) && (rq[0].due == cyc);
      s_bus.readdata = s_bus.readdatavalid ? rq[0].d : 16'h0;
      @(negedge clk);
      if (32'(pending_cnt) > peak) peak = 32'(pending_cnt);
      if (s_bus.read && !s_bus.waitrequest) begin
        if (n_acc < 6) chk($sformatf("t2 order%0d", n_acc), s_bus.address, exp_ord[n_acc]);
        rq.push_back('{cyc + 5, s_bus.address[15:0] ^ 16'h5A5A});
        n_acc++;
      end
      if (s_bus.readdatavalid) void'(rq.pop_front());
      if (m0_bus.readdatavalid) begin
        exp_dat = (16'h0100 + 16'(n0)) ^ 16'h5A5A;
        chk($sformatf("t2 m0 data%0d", n0), m0_bus.readdata, exp_dat);
        n0++;
      end
      if (m1_bus.readdatavalid) begin
        exp_dat = (16'h0200 + 16'(n1)) ^ 16'h5A5A;
        chk($sformatf("t2 m1 data%0d", n1), m1_bus.readdata, exp_dat);
        n1++;
      end
      if (m0_bus.read && !m0_bus.waitrequest) i0++;
      if (m1_bus.read && !m1_bus.waitrequest) i1++;
      cyc++;
    end
    chk("t2 accepts", n_acc, 6);
    chk("t2 m0 pulses", n0, 3);
    chk("t2 m1 pulses", n1, 3);
    chk("t2 peak pending", peak, 5);
    chk("t2 drained", pending_cnt, 0);

    // ---- FIFO full: 9th read stalls, write passes, first return releases ----
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cyc0(1'b1, 1'b0, 25'h400 + 25'(k), 1'b0);
      chk($sformatf("t4 rd%0d s_read", k), s_bus.read, 1);
      chk($sformatf("t4 rd%0d m0_wait", k), m0_bus.waitrequest, 0);
      chk($sformatf("t4 rd%0d pending", k), pending_cnt, k);
    end
    cyc0(1'b1, 1'b0, 25'h408, 1'b0);
    chk("t4 ninth s_read", s_bus.read, 0);
    chk("t4 ninth m0_wait", m0_bus.waitrequest, 1);
    chk("t4 full pending", pending_cnt, 8);
    cyc0(1'b0, 1'b1, 25'h500, 1'b0);
    chk("t4 write s_write", s_bus.write, 1);
    chk("t4 write m0_wait", m0_bus.waitrequest, 0);
    chk("t4 write s_be", s_bus.byteenable, 2'b11);
    chk("t4 write pending", pending_cnt, 8);
    cyc0(1'b1, 1'b0, 25'h408, 1'b1);
    chk("t4 ret s_read", s_bus.read, 0);
    chk("t4 ret m0_wait", m0_bus.waitrequest, 1);
    chk("t4 ret m0_rdv", m0_bus.readdatavalid, 1);
    chk("t4 ret m1_rdv", m1_bus.readdatavalid, 0);
    cyc0(1'b1, 1'b0, 25'h408, 1'b0);
    chk("t4 release s_read", s_bus.read, 1);
    chk("t4 release addr", s_bus.address, 25'h408);
    chk("t4 release m0_wait", m0_bus.waitrequest, 0);
    chk("t4 release pending", pending_cnt, 7);
    cyc0(1'b0, 1'b0, 25'h0, 1'b0);
    chk("t4 refill pending", pending_cnt, 8);

    // ---- asynchronous reset with reads outstanding ----
    @(posedge clk); #1;
    m0_bus.read = 1'b1; m1_bus.read = 1'b1; s_bus.readdatavalid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6 s_read", s_bus.read, 0);
    chk("t6 s_write", s_bus.write, 0);
    chk("t6 m0_wait", m0_bus.waitrequest, 1);
    chk("t6 m1_wait", m1_bus.waitrequest, 1);
    chk("t6 m0_rdv", m0_bus.readdatavalid, 0);
    chk("t6 m1_rdv", m1_bus.readdatavalid, 0);
    chk("t6 pending", pending_cnt, 0);
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6 post pending", pending_cnt, 0);
    chk("t6 post m0_wait", m0_bus.waitrequest, 0);
    chk("t6 post m1_wait", m1_bus.waitrequest, 1);

    // ---- ID FIFO on its own: push and pop together while full ----
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      f_push = 1'b1; f_pop = 1'b0; f_din = k[0];
    end
    @(posedge clk); #1;
    f_push = 1'b0;
    @(negedge clk);
    chk("t5 full", f_full, 1);
    chk("t5 count8", f_count, 8);
    chk("t5 head", f_dout, 0);
    @(posedge clk); #1;
    f_push = 1'b1; f_pop = 1'b1; f_din = 1'b1;
    @(posedge clk); #1;
    f_push = 1'b0; f_pop = 1'b0;
    @(negedge clk);
    chk("t5 pushpop count", f_count, 8);
    chk("t5 pushpop full", f_full, 1);
    fexp[0] = 1; fexp[1] = 0; fexp[2] = 1; fexp[3] = 0;
    fexp[4] = 1; fexp[5] = 0; fexp[6] = 1; fexp[7] = 1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      f_pop = 1'b1;
      #1;
      chk($sformatf("t5 pop%0d", k), f_dout, fexp[k]);
    end
    @(posedge clk); #1;
    f_pop = 1'b0;
    @(negedge clk);
    chk("t5 empty", f_empty, 1);
    chk("t5 count0", f_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
